// File: rtl/alu_out_pipe.sv
// STAGES-deep handshaked register pipeline for ALU results: collapses bubbles
// under backpressure, flushes synchronously and reports its occupancy.
module alu_out_pipe #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(STAGES+1)-1:0]  count
);

  localparam int unsigned CW = $clog2(STAGES + 1);

  logic [WIDTH-1:0]  data_q     [STAGES];
  logic [WIDTH-1:0]  src_data_c [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] adv_c;
  logic [STAGES-1:0] src_valid_c;
  logic [CW-1:0]     count_q;
  logic              in_fire_c;
  logic              out_fire_c;

  // A stage may move when any stage at or below it (towards the output) is empty,
  // or the consumer is taking the last item.
  always_comb begin : p_adv
    logic tail_full;
    adv_c     = '0;
    tail_full = 1'b1;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      tail_full = tail_full & valid_q[i];
      adv_c[i]  = out_ready | ~tail_full;
    end
  end

  assign in_ready   = adv_c[0];
  assign in_fire_c  = in_valid & adv_c[0] & ~flush;
  assign out_fire_c = valid_q[STAGES-1] & out_ready;

  // Source of each stage: the producer for stage 0, the previous stage otherwise.
  always_comb begin
    src_valid_c = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      src_data_c[i] = in_data;
    end
    src_valid_c[0] = in_fire_c;
    for (int i = 1; i < int'(STAGES); i++) begin
      src_valid_c[i] = valid_q[i-1];
      src_data_c[i]  = data_q[i-1];
    end
  end

  // Stage registers; data only loads from a valid source so bubbles do not toggle it.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else if (flush) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (adv_c[i]) begin
          valid_q[i] <= src_valid_c[i];
          if (src_valid_c[i]) begin
            data_q[i] <= src_data_c[i];
          end
        end
      end
      count_q <= count_q + CW'(in_fire_c) - CW'(out_fire_c);
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign count     = count_q;

endmodule
